// File: rtl/ov7670_pkg.sv
// Shared mode constants, bar colour table, FSM state type and byte packing for the OV7670 stream emulator.
package ov7670_pkg;

  localparam logic [1:0] MODE_BARS  = 2'd0;
  localparam logic [1:0] MODE_RAMP  = 2'd1;
  localparam logic [1:0] MODE_SOLID = 2'd2;

  localparam logic [11:0] BAR_TBL [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                          12'hF0F, 12'hF00, 12'h00F, 12'h000};

  typedef enum logic {ST_IDLE, ST_FRAME} tx_state_t;

  // sel=0 gives the first byte of a pixel {4'h0,R}, sel=1 the second byte {G,B}
  function automatic logic [7:0] pix_bytes(input logic [11:0] rgb444, input logic sel);
    return sel ? rgb444[7:0] : {4'h0, rgb444[11:8]};
  endfunction

endpackage

// File: rtl/ov7670_tx_pattern.sv
// Combinational test-pattern generator: pixel position, mode and colour to one RGB444 pixel.
module ov7670_tx_pattern
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int XW       = 10,
  parameter int YW       = 9
) (
  input  logic [XW-1:0] i_x,
  input  logic [YW-1:0] i_y,
  input  logic [1:0]    i_mode,
  input  logic [11:0]   i_color,
  output logic [11:0]   o_pix
);

  logic [2:0] w_bar;
  logic [7:0] w_x8;
  logic [3:0] w_y4;

  always_comb begin
    w_x8  = 8'(i_x);
    w_y4  = 4'(i_y);
    // positions past the active width only occur while HREF is low, so truncation is harmless
    w_bar = 3'((32'(i_x) * 32'd8) / 32'(H_ACTIVE));
    case (i_mode)
      MODE_RAMP:  o_pix = {w_x8[3:0], w_y4, w_x8[7:4]};
      MODE_SOLID: o_pix = i_color;
      default:    o_pix = BAR_TBL[w_bar];
    endcase
  end

endmodule

// File: rtl/ov7670_stream_tx.sv
// OV7670 camera-output emulator: PCLK/VSYNC/HREF and RGB444 byte stream driving the capture chain.
// Define OV7670_TX_FRAME_CNT_EN to add the 16-bit frame_cnt output.
module ov7670_stream_tx
  import ov7670_pkg::*;
#(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_BLANK  = 288,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 17,
  parameter int V_FP     = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [1:0]  mode,
  input  logic [11:0] color,
  output logic        pclk_o,
  output logic        vsync_o,
  output logic        href_o,
  output logic [7:0]  d_o,
  output logic        busy,
  output logic        frame_done
`ifdef OV7670_TX_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOT = 2*H_ACTIVE + H_BLANK;
  localparam int V_TOT = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT_END = HW'(2*H_ACTIVE);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_SYNC_E  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ACT_LO  = VW'(V_SYNC + V_BP);
  localparam logic [VW-1:0] V_ACT_HI  = VW'(V_SYNC + V_BP + V_ACTIVE);

  tx_state_t     r_state;
  logic          r_ph;
  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic [1:0]    r_mode;
  logic [11:0]   r_color;

  logic [HW-1:0] w_h_nxt;
  logic [VW-1:0] w_v_nxt;
  logic [VW-1:0] w_y;
  logic          w_wrap;
  logic          w_start;
  logic          w_fr_nxt;
  logic          w_href;
  logic          w_vsync;
  logic [1:0]    w_mode;
  logic [11:0]   w_color;
  logic [11:0]   w_pix;
  logic [7:0]    w_d;

  assign pclk_o = r_ph;

  // Position of the slot about to be emitted at the next PCLK falling edge
  always_comb begin
    w_h_nxt = r_hcnt;
    w_v_nxt = r_vcnt;
    w_wrap  = 1'b0;
    if (r_state == ST_IDLE) begin
      w_h_nxt = '0;
      w_v_nxt = '0;
    end else if (r_hcnt == H_LAST) begin
      w_h_nxt = '0;
      if (r_vcnt == V_LAST) begin
        w_v_nxt = '0;
        w_wrap  = 1'b1;
      end else begin
        w_v_nxt = r_vcnt + 1'b1;
      end
    end else begin
      w_h_nxt = r_hcnt + 1'b1;
    end
  end

  assign w_start  = en && ((r_state == ST_IDLE) || w_wrap);
  assign w_fr_nxt = (r_state == ST_FRAME) ? !(w_wrap && !en) : en;
  // a new frame uses the freshly sampled mode/colour from its very first slot
  assign w_mode   = w_start ? mode  : r_mode;
  assign w_color  = w_start ? color : r_color;
  assign w_y      = w_v_nxt - V_ACT_LO;
  assign w_vsync  = w_fr_nxt && (w_v_nxt < V_SYNC_E);
  assign w_href   = w_fr_nxt && (w_v_nxt >= V_ACT_LO) && (w_v_nxt < V_ACT_HI) &&
                    (w_h_nxt < H_ACT_END);
  assign w_d      = w_href ? pix_bytes(w_pix, w_h_nxt[0]) : 8'h00;

  ov7670_tx_pattern #(
    .H_ACTIVE (H_ACTIVE),
    .XW       (HW-1),
    .YW       (VW)
  ) u_pattern (
    .i_x     (w_h_nxt[HW-1:1]),
    .i_y     (w_y),
    .i_mode  (w_mode),
    .i_color (w_color),
    .o_pix   (w_pix)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ph       <= 1'b0;
      r_state    <= ST_IDLE;
      r_hcnt     <= '0;
      r_vcnt     <= '0;
      r_mode     <= MODE_BARS;
      r_color    <= '0;
      vsync_o    <= 1'b0;
      href_o     <= 1'b0;
      d_o        <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef OV7670_TX_FRAME_CNT_EN
      frame_cnt  <= '0;
`endif
    end else begin
      r_ph       <= ~r_ph;
      frame_done <= 1'b0;
      // slot boundary: PCLK falling edge
      if (r_ph) begin
        r_state    <= w_fr_nxt ? ST_FRAME : ST_IDLE;
        r_hcnt     <= w_h_nxt;
        r_vcnt     <= w_v_nxt;
        vsync_o    <= w_vsync;
        href_o     <= w_href;
        d_o        <= w_d;
        busy       <= w_fr_nxt;
        frame_done <= w_wrap;
        if (w_start) begin
          r_mode  <= mode;
          r_color <= color;
        end
`ifdef OV7670_TX_FRAME_CNT_EN
        if (w_wrap) frame_cnt <= frame_cnt + 16'd1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_ov7670_stream_tx.sv
// Self-checking bench for ov7670_stream_tx: slot-level reference model, vector table and corner sequences.
module tb_ov7670_stream_tx;

  localparam int H_A   = 8;
  localparam int V_A   = 4;
  localparam int H_B   = 4;
  localparam int V_S   = 1;
  localparam int V_B   = 1;
  localparam int V_F   = 1;
  localparam int LINE  = 2*H_A + H_B;
  localparam int SLOTS = LINE * (V_S + V_B + V_A + V_F);
  localparam int ACT0  = V_S + V_B;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [11:0] color = 12'h000;
  logic        pclk_o, vsync_o, href_o, busy, frame_done;
  logic [7:0]  d_o;
`ifdef OV7670_TX_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  ov7670_stream_tx #(
    .H_ACTIVE (H_A), .V_ACTIVE (V_A), .H_BLANK (H_B),
    .V_SYNC (V_S), .V_BP (V_B), .V_FP (V_F)
  ) dut (
    .clk (clk), .reset_n (reset_n), .en (en), .mode (mode), .color (color),
    .pclk_o (pclk_o), .vsync_o (vsync_o), .href_o (href_o), .d_o (d_o),
    .busy (busy), .frame_done (frame_done)
`ifdef OV7670_TX_FRAME_CNT_EN
    , .frame_cnt (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference model state: frame slot index p = line*LINE + slot
  logic        m_busy = 1'b0;
  int          m_p = 0;
  logic [1:0]  m_mode = 2'd0;
  logic [11:0] m_col = 12'h000;
  logic [15:0] m_fcnt = 16'd0;
  logic        p_hr = 1'b0;
  logic [7:0]  p_d = 8'h00;

  typedef struct {
    int         p;
    logic       vs;
    logic       hr;
    logic [7:0] d;
  } vec_t;
  vec_t tbl [16];

  logic       cap_vs [SLOTS];
  logic       cap_hr [SLOTS];
  logic [7:0] cap_d  [SLOTS];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] ref_pix(input logic [1:0] md, input logic [11:0] col,
                                          input int x, input int y);
    logic [11:0] r;
    int bar;
    bar = x * 8 / H_A;
    case (bar)
      0: r = 12'hFFF;  1: r = 12'hFF0;  2: r = 12'h0FF;  3: r = 12'h0F0;
      4: r = 12'hF0F;  5: r = 12'hF00;  6: r = 12'h00F;  default: r = 12'h000;
    endcase
    if (md == 2'd1) r = 12'((x % 16) * 256 + (y % 16) * 16 + (x / 16) % 16);
    else if (md == 2'd2) r = col;
    return r;
  endfunction

  // advance one byte slot (2 clk), checking the mid clock and the boundary outputs
  task automatic step();
    logic e_done, e_vs, e_hr;
    logic [7:0] e_d;
    logic [11:0] px;
    int ln, s;
    e_done = 1'b0;
    if (m_busy) begin
      m_p++;
      if (m_p == SLOTS) begin
        e_done = 1'b1;
        m_p    = 0;
        m_fcnt = m_fcnt + 16'd1;
        if (en) begin m_mode = mode; m_col = color; end
        else m_busy = 1'b0;
      end
    end else if (en) begin
      m_busy = 1'b1; m_p = 0; m_mode = mode; m_col = color;
    end
    ln   = m_p / LINE;
    s    = m_p % LINE;
    e_vs = m_busy && (ln < V_S);
    e_hr = m_busy && (ln >= ACT0) && (ln < ACT0 + V_A) && (s < 2*H_A);
    e_d  = 8'h00;
    if (e_hr) begin
      px  = ref_pix(m_mode, m_col, s / 2, ln - ACT0);
      e_d = (s % 2 == 0) ? {4'h0, px[11:8]} : px[7:0];
    end
    @(posedge clk); #1;
    chk("pclk_high", pclk_o, 1);
    chk("done_mid", frame_done, 0);
    chk("href_hold", href_o, p_hr);
    chk("d_hold", d_o, p_d);
    @(posedge clk); #1;
    chk("pclk_low", pclk_o, 0);
    chk("vsync", vsync_o, e_vs);
    chk("href", href_o, e_hr);
    chk("data", d_o, e_d);
    chk("busy", busy, m_busy);
    chk("frame_done", frame_done, e_done);
`ifdef OV7670_TX_FRAME_CNT_EN
    chk("frame_cnt", frame_cnt, m_fcnt);
`endif
    p_hr = e_hr;
    p_d  = e_d;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n, nd, gap, pulses, run, minrun, maxrun, vsl, nwrong;
    logic got, prev;
    logic [7:0] q[$];
`ifdef OV7670_TX_FRAME_CNT_EN
    logic [15:0] fc0;
`endif
    tbl[0]  = '{0,   1'b1, 1'b0, 8'h00};
    tbl[1]  = '{19,  1'b1, 1'b0, 8'h00};
    tbl[2]  = '{20,  1'b0, 1'b0, 8'h00};
    tbl[3]  = '{40,  1'b0, 1'b1, 8'h0F};
    tbl[4]  = '{41,  1'b0, 1'b1, 8'hFF};
    tbl[5]  = '{42,  1'b0, 1'b1, 8'h0F};
    tbl[6]  = '{43,  1'b0, 1'b1, 8'hF0};
    tbl[7]  = '{44,  1'b0, 1'b1, 8'h00};
    tbl[8]  = '{47,  1'b0, 1'b1, 8'hF0};
    tbl[9]  = '{48,  1'b0, 1'b1, 8'h0F};
    tbl[10] = '{49,  1'b0, 1'b1, 8'h0F};
    tbl[11] = '{51,  1'b0, 1'b1, 8'h00};
    tbl[12] = '{53,  1'b0, 1'b1, 8'h0F};
    tbl[13] = '{55,  1'b0, 1'b1, 8'h00};
    tbl[14] = '{56,  1'b0, 1'b0, 8'h00};
    tbl[15] = '{115, 1'b0, 1'b1, 8'h00};

    // reset values
    #12;
    chk("rst_pclk", pclk_o, 0);
    chk("rst_vsync", vsync_o, 0);
    chk("rst_href", href_o, 0);
    chk("rst_d", d_o, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    @(negedge clk); reset_n = 1'b1;

    // idle with en low: free-running PCLK, quiet outputs
    repeat (50) step();

    // colour bars frame, en dropped right after it starts
    en = 1'b1; mode = 2'd0;
    for (int i = 0; i < SLOTS; i++) begin
      step();
      if (i == 0) en = 1'b0;
      cap_vs[i] = vsync_o; cap_hr[i] = href_o; cap_d[i] = d_o;
    end
    step();
    chk("bars_done", frame_done, 1);
    chk("bars_idle", busy, 0);
    for (int i = 0; i < 16; i++) begin
      chk("tbl_vsync", cap_vs[tbl[i].p], tbl[i].vs);
      chk("tbl_href", cap_hr[tbl[i].p], tbl[i].hr);
      chk("tbl_data", cap_d[tbl[i].p], tbl[i].d);
    end
    pulses = 0; run = 0; minrun = 999; maxrun = 0; vsl = 0;
    for (int i = 0; i < SLOTS; i++) begin
      if (cap_hr[i] && (i == 0 || !cap_hr[i-1])) pulses++;
      if (cap_hr[i]) run++;
      else if (run > 0) begin
        if (run < minrun) minrun = run;
        if (run > maxrun) maxrun = run;
        run = 0;
      end
      if (cap_vs[i]) vsl++;
    end
    chk("href_pulses", pulses, V_A);
    chk("href_min_len", minrun, 2*H_A);
    chk("href_max_len", maxrun, 2*H_A);
    chk("vsync_slots", vsl, LINE);

    // solid colour and frame_done latency
    en = 1'b1; mode = 2'd2; color = 12'hA5C;
    step();
    en = 1'b0; color = 12'h123;
    n = 0; got = 1'b0;
    while (n < 300 && !got) begin
      step(); n++;
      if (href_o) q.push_back(d_o);
      if (frame_done) got = 1'b1;
    end
    chk("solid_done_seen", got, 1);
    chk("solid_done_clk", n * 2, 2 * SLOTS);
    nwrong = 0;
    foreach (q[i]) if (q[i] != ((i % 2 == 0) ? 8'h0A : 8'h5C)) nwrong++;
    chk("solid_bytes", q.size(), 2*H_A*V_A);
    chk("solid_wrong", nwrong, 0);

    // back-to-back frames
`ifdef OV7670_TX_FRAME_CNT_EN
    fc0 = frame_cnt;
`endif
    en = 1'b1; mode = 2'($urandom_range(0, 3)); color = 12'($urandom);
    step();
    n = 0; nd = 0; gap = 0;
    while (n < 400 && nd < 2) begin
      step(); n++;
      if (frame_done) begin nd++; en = 1'b0; end
      if (!busy && nd < 2) gap++;
    end
    chk("b2b_done_cnt", nd, 2);
    chk("b2b_gap", gap, 0);
    chk("b2b_length", n, 2 * SLOTS);
`ifdef OV7670_TX_FRAME_CNT_EN
    chk("b2b_frame_cnt", frame_cnt - fc0, 2);
`endif

    // en dropped in the middle of line 2
    en = 1'b1; mode = 2'd1;
    step();
    prev = href_o; pulses = 0; n = 0; got = 1'b0;
    while (n < 300 && !got) begin
      if (n == 49) en = 1'b0;
      step(); n++;
      if (href_o && !prev) pulses++;
      prev = href_o;
      if (frame_done) got = 1'b1;
    end
    chk("drop_done", got, 1);
    chk("drop_lines", pulses, V_A);
    chk("drop_busy", busy, 0);
    step();
    chk("drop_stays_idle", busy, 0);

    // asynchronous reset during an HREF-high slot
    en = 1'b1; mode = 2'd0;
    repeat (45) step();
    chk("pre_rst_href", href_o, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_href", href_o, 0);
    chk("arst_d", d_o, 0);
    chk("arst_vsync", vsync_o, 0);
    chk("arst_busy", busy, 0);
    chk("arst_pclk", pclk_o, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    m_busy = 1'b0; m_p = 0; m_fcnt = 16'd0; p_hr = 1'b0; p_d = 8'h00;
    step();
    chk("restart_vsync", vsync_o, 1);
    chk("restart_busy", busy, 1);
    en = 1'b0;
    repeat (SLOTS) step();
    chk("restart_done", frame_done, 1);

    // randomized inputs against the model
    for (int i = 0; i < 600; i++) begin
      en    = ($urandom_range(0, 5) == 0);
      mode  = 2'($urandom_range(0, 3));
      color = 12'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
